fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 5, word-index width of the instruction memory address.
REQ-002 Parameter INST_W, default 32, instruction word width, equal to the memory read width.
REQ-003 Parameter RESET_PC, default 0, word index loaded into the PC at reset.
REQ-004 Parameter HALT_INST, default 32'h0010_0073 (ebreak), the encoding that halts fetch.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  leaves IDLE and begins fetching.
REQ-008 redir_valid  input  1  branch/jump redirect request from execute.
REQ-009 redir_pc  input  ADDR_W  redirect target word index.
REQ-010 imem_addr  output  ADDR_W  address to the combinational instruction memory.
REQ-011 imem_data  input  INST_W  instruction returned by memory in the same cycle.
REQ-012 out_valid  output  1  IF/ID register holds a valid instruction.
REQ-013 out_ready  input  1  decode accepts the instruction this cycle.
REQ-014 out_inst  output  INST_W  registered instruction.
REQ-015 out_pc  output  ADDR_W  word index the instruction was fetched from.
REQ-016 halted  output  1  high while the FSM is in HALTED.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and HALTED.
REQ-018 imem_addr SHALL equal the PC register combinationally in every state.
REQ-019 In IDLE, start=1 SHALL move the FSM to RUN on the next edge without fetching.
REQ-020 A fetch SHALL occur in RUN when out_valid=0 or out_ready=1.
- Effects: out_inst<=imem_data, out_pc<=PC, out_valid<=1, PC<=PC+1.
REQ-021 PC increment SHALL wrap modulo 2^ADDR_W (all-ones -> 0).
REQ-022 A stall (out_valid=1, out_ready=0, no redirect) SHALL hold PC, out_inst, out_pc and out_valid unchanged.
REQ-023 When a fetched imem_data equals HALT_INST, the instruction SHALL still be delivered, PC SHALL increment, and the FSM SHALL enter HALTED.
REQ-024 In HALTED, no fetch SHALL occur; out_valid SHALL clear when the pending instruction is consumed (out_ready=1).
REQ-025 When no fetch occurs and out_valid=1 with out_ready=1, out_valid SHALL clear on the next edge.
REQ-026 redir_valid=1 in any state SHALL take effect on the next edge: PC<=redir_pc, out_valid<=0 (flush), state<=RUN.
- Redirect has priority over start, fetch, stall and halt detection.
- No instruction is fetched in the redirect cycle.
REQ-027 First fetch latency after a redirect or after start SHALL be 1 cycle: the instruction at the target appears with out_valid=1 two edges after the request.

Reset
REQ-028 When rst=1 at an edge, the block SHALL apply reset regardless of other inputs:
- state=IDLE, PC=RESET_PC, out_valid=0, out_inst=0, out_pc=0, halted=0.
REQ-029 Reset asserted mid-stall or mid-HALTED SHALL discard the held instruction.

Configuration
REQ-030 With macro FETCH_PERF_EN defined, the block SHALL add two outputs and behave as follows:
- fetch_cnt (16 bits): increments per fetch.
- stall_cnt (16 bits): increments per stall cycle.
- Both saturate at 16'hFFFF and reset to 0.
REQ-031 Without FETCH_PERF_EN, these ports and counters SHALL be absent and behaviour SHALL be otherwise identical.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the FSM state enum (IDLE, RUN, HALTED) and the default HALT_INST constant.
REQ-033 The PC register and next-PC select SHALL be a sub-module pc_reg; the FSM and IF/ID register SHALL reside in fetch_unit.

Verification
REQ-034 The bench SHALL cover the following directed scenarios, each with a 32-word memory image:
- Reset, start, out_ready=1: out_pc = 0, 1, 2, 3 on consecutive cycles; out_inst matches image words 0-3.
- out_ready=0 for 3 cycles at out_pc=2: out_pc and out_inst hold at word 2; imem_addr holds at 3.
- redir_valid with redir_pc=20 while out_valid=1: out_valid=0 next cycle, then out_pc=20.
- HALT_INST at word 5: word 5 is delivered, halted=1, no further fetch; a redirect to 0 resumes with halted=0.
- Run from redirect to 30 without stall: out_pc = 30, 31, 0 (wrap).
- rst asserted during a stall: all outputs return to reset values; with FETCH_PERF_EN, fetch_cnt and stall_cnt read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Brief  : Shared FSM state encoding and default halt encoding for fetch_unit.
// Rev    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // ebreak
    localparam logic [31:0] C_HALT_INST = 32'h0010_0073;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit_if
// Brief  : Instruction-memory, redirect and IF/ID handshake bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int ADDR_W = 5,
    parameter int INST_W = 32
);
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  redir_valid, redir_pc, imem_data, out_ready,
        output imem_addr, out_valid, out_inst, out_pc
    );

    modport slave (
        output redir_valid, redir_pc, imem_data, out_ready,
        input  imem_addr, out_valid, out_inst, out_pc
    );
endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_pc_reg.sv
`default_nettype none
// ============================================================================
// Module : pc_reg
// Brief  : Program counter with redirect load and wrapping increment.
// Rev    : 1.0 - initial release
// ============================================================================
module pc_reg #(
    parameter int ADDR_W   = 5,
    parameter int RESET_PC = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [ADDR_W-1:0] i_load_pc,
    input  wire logic              i_incr,
    output logic      [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;

    // Redirect outranks increment; the adder wraps naturally at ADDR_W bits.
    always_comb begin
        w_pc_nxt = r_pc;
        if (i_load) begin
            w_pc_nxt = i_load_pc;
        end else if (i_incr) begin
            w_pc_nxt = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_pc <= w_pc_nxt;
        end
    end

    assign o_pc = r_pc;

endmodule : pc_reg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : fetch_unit
// Brief  : Instruction fetch FSM and IF/ID register; optional perf counters
//          (fetch_cnt/stall_cnt) built when FETCH_PERF_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = 5,
    parameter int                INST_W    = 32,
    parameter int                RESET_PC  = 0,
    parameter logic [INST_W-1:0] HALT_INST = C_HALT_INST
) (
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    start,
    fetch_unit_if.master bus,
    output logic         halted
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]  fetch_cnt,
    output logic [15:0]  stall_cnt
`endif
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_pc;
    logic              w_fetch;
    logic              r_out_valid;
    logic [INST_W-1:0] r_out_inst;
    logic [ADDR_W-1:0] r_out_pc;

    // A fetch needs the IF/ID slot free (empty or draining) and no redirect.
    assign w_fetch = (r_state == RUN) && (!r_out_valid || bus.out_ready)
                     && !bus.redir_valid;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .rst       (rst),
        .i_load    (bus.redir_valid),
        .i_load_pc (bus.redir_pc),
        .i_incr    (w_fetch),
        .o_pc      (w_pc)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_fetch && (bus.imem_data == HALT_INST)) begin
                    w_state_nxt = HALTED;
                end
            end
            HALTED: begin
                w_state_nxt = HALTED;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (bus.redir_valid) begin
            w_state_nxt = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // IF/ID register: flush on redirect, load on fetch, drain when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_inst  <= '0;
            r_out_pc    <= '0;
        end else if (bus.redir_valid) begin
            r_out_valid <= 1'b0;
        end else if (w_fetch) begin
            r_out_valid <= 1'b1;
            r_out_inst  <= bus.imem_data;
            r_out_pc    <= w_pc;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.imem_addr = w_pc;
    assign bus.out_valid = r_out_valid;
    assign bus.out_inst  = r_out_inst;
    assign bus.out_pc    = r_out_pc;
    assign halted        = (r_state == HALTED);

`ifdef FETCH_PERF_EN
    logic        w_stall;
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;

    assign w_stall = r_out_valid && !bus.out_ready && !bus.redir_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= 16'd0;
            r_stall_cnt <= 16'd0;
        end else begin
            if (w_fetch && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_unit
// Brief  : Directed self-checking bench for fetch_unit with accept scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int ADDR_W = 5;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halted;
    logic [31:0] mem [32];
    exp_t        exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
`ifdef FETCH_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    fetch_unit_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    fetch_unit #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .RESET_PC (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .halted (halted)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt (fetch_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int pc);
        exp_t e;
        e.pc   = ADDR_W'(pc);
        e.inst = mem[pc];
        exp_q.push_back(e);
    endtask

    // Scoreboard: an instruction is consumed when valid & ready with no flush.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.out_valid && bus.out_ready && !bus.redir_valid) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected", 32'(bus.out_pc), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", 32'(bus.out_pc), 32'(e.pc));
                chk("sb_inst", bus.out_inst, e.inst);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_inst"}, bus.out_inst, 32'd0);
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
`ifdef FETCH_PERF_EN
        chk({tag, "_fcnt"}, 32'(fetch_cnt), 32'd0);
        chk({tag, "_scnt"}, 32'(stall_cnt), 32'd0);
`endif
    endtask

    task automatic chk_out(input string tag, input int pc);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_pc"}, 32'(bus.out_pc), 32'(pc));
        chk({tag, "_inst"}, bus.out_inst, mem[pc]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1357_0000 + 32'(i) * 32'h0101;
        rst = 1'b1; start = 1'b0;
        bus.out_ready = 1'b0; bus.redir_valid = 1'b0; bus.redir_pc = '0;
        tick(); tick();
        rst = 1'b0;
        chk_reset("rst");

        // Start then four sequential fetches
        start = 1'b1; bus.out_ready = 1'b1;
        push_exp(0); push_exp(1);
        tick(); start = 1'b0;
        chk("start_nofetch", 32'(bus.out_valid), 32'd0);
        tick(); chk_out("seq0", 0);
        tick(); chk_out("seq1", 1);
        tick(); chk_out("seq2", 2);

        // Three-cycle stall on word 2
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall", 2);
            chk("stall_addr", 32'(bus.imem_addr), 32'd3);
        end
        bus.out_ready = 1'b1; push_exp(2);
        tick(); chk_out("seq3", 3);

        // Redirect to 20 flushes word 3
        bus.redir_valid = 1'b1; bus.redir_pc = 5'd20;
        tick(); bus.redir_valid = 1'b0;
        chk("redir_flush", 32'(bus.out_valid), 32'd0);
        chk("redir_addr", 32'(bus.imem_addr), 32'd20);
        push_exp(20);
        tick(); chk_out("redir20", 20);
        tick(); chk_out("redir21", 21);

        // Halt instruction at word 5
        mem[5] = C_HALT_INST;
        bus.redir_valid = 1'b1; bus.redir_pc = 5'd3;
        tick(); bus.redir_valid = 1'b0;
        chk("redir3_flush", 32'(bus.out_valid), 32'd0);
        push_exp(3); push_exp(4); push_exp(5);
        tick(); chk_out("h3", 3);
        tick(); chk_out("h4", 4);
        chk("h4_halted", 32'(halted), 32'd0);
        tick(); chk_out("h5", 5);
        chk("h5_halted", 32'(halted), 32'd1);
        tick();
        chk("halt_drain", 32'(bus.out_valid), 32'd0);
        chk("halt_addr", 32'(bus.imem_addr), 32'd6);
        tick();
        chk("halt_hold_valid", 32'(bus.out_valid), 32'd0);
        chk("halt_hold_addr", 32'(bus.imem_addr), 32'd6);
        chk("halt_hold", 32'(halted), 32'd1);

        // Redirect out of HALTED
        bus.redir_valid = 1'b1; bus.redir_pc = 5'd0;
        tick(); bus.redir_valid = 1'b0;
        mem[5] = 32'h1357_0000 + 32'd5 * 32'h0101;
        chk("resume_halted", 32'(halted), 32'd0);
        chk("resume_valid", 32'(bus.out_valid), 32'd0);
        push_exp(0);
        tick(); chk_out("resume0", 0);
        tick(); chk_out("resume1", 1);

        // Wrap from 31 to 0
        bus.redir_valid = 1'b1; bus.redir_pc = 5'd30;
        tick(); bus.redir_valid = 1'b0;
        push_exp(30); push_exp(31);
        tick(); chk_out("wrap30", 30);
        tick(); chk_out("wrap31", 31);
        tick(); chk_out("wrap0", 0);
        chk("wrap_addr", 32'(bus.imem_addr), 32'd1);

        // Reset in the middle of a stall
        bus.out_ready = 1'b0;
        tick(); tick();
        chk_out("pre_rst", 0);
`ifdef FETCH_PERF_EN
        chk("perf_fcnt", 32'(fetch_cnt), 32'd14);
        chk("perf_scnt", 32'(stall_cnt), 32'd5);
`endif
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_reset("stall_rst");
        bus.out_ready = 1'b1;
        tick(); tick();
        chk("idle_nofetch", 32'(bus.out_valid), 32'd0);
        chk("idle_addr", 32'(bus.imem_addr), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit
`default_nettype wire
